// File: rtl/spad_itof_pkg.sv
// spad_itof_pkg
// Shared definitions for the SPAD indirect time-of-flight front end:
//   - spad_state_t : frame FSM states (IDLE, INTEGRATE, HOLD)
//   - SPAD_CNT_W, SPAD_PERIOD, SPAD_N_PERIODS : default block parameters,
//     shared with output_buffer so the memory widths line up
//   - cnt_width()  : counter width helper that never returns zero
// No ports (package).
package spad_itof_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INTEGRATE = 2'd1,
        HOLD      = 2'd2
    } spad_state_t;

    localparam int unsigned SPAD_CNT_W     = 12;
    localparam int unsigned SPAD_PERIOD    = 16;
    localparam int unsigned SPAD_N_PERIODS = 256;

    // Width needed to hold 0..n-1; a count of 1 still gets a 1-bit register.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spad_pulse_sync.sv
// spad_pulse_sync
// Two-flop synchronizer followed by a rising-edge detector for the
// asynchronous SPAD detection line. Only instantiated when SPAD_SYNC_EN
// is defined in spad_tap_accumulator.
// Ports:
//   clk     in  1  block clock
//   rst_n   in  1  synchronous active-low reset; all flops clear to 0
//   spad_in in  1  raw SPAD detection signal
//   pulse   out 1  one-cycle pulse per rising edge, 2 cycles after sampling
module spad_pulse_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spad_in,
    output logic pulse
);

    // [0] first sync stage, [1] second sync stage, [2] previous synced value
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], spad_in};
        end
    end

    always_comb begin
        pulse = sync_q[1] & ~sync_q[2];
    end

endmodule

// File: rtl/spad_tap_accumulator.sv
// spad_tap_accumulator
// Two-tap photon accumulator for indirect ToF. Each modulation period of
// PERIOD cycles is split in half: detections in the first half count into
// memory1 (tap 0), the second half into memory2 (tap 1). After N_PERIODS
// periods the frame is held on the outputs until the consumer acks.
// Build option: define SPAD_SYNC_EN to route spad_in through
// spad_pulse_sync (2-flop sync + rising-edge detect, 2-cycle latency);
// otherwise spad_in is taken as synchronous, one count per high cycle.
// Ports:
//   clk       in  1      block clock
//   rst_n     in  1      synchronous active-low reset
//   start     in  1      begin a frame (IDLE, or HOLD together with out_ack)
//   spad_in   in  1      SPAD detection signal
//   out_ack   in  1      consumer has taken the held frame
//   memory1   out CNT_W  tap-0 count, saturating
//   memory2   out CNT_W  tap-1 count, saturating
//   out_valid out 1      high exactly in HOLD
//   busy      out 1      high exactly in INTEGRATE
module spad_tap_accumulator
    import spad_itof_pkg::*;
#(
    parameter int unsigned CNT_W     = SPAD_CNT_W,
    parameter int unsigned PERIOD    = SPAD_PERIOD,
    parameter int unsigned N_PERIODS = SPAD_N_PERIODS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             spad_in,
    input  logic             out_ack,
    output logic [CNT_W-1:0] memory1,
    output logic [CNT_W-1:0] memory2,
    output logic             out_valid,
    output logic             busy
);

    localparam int unsigned PH_W = cnt_width(PERIOD);
    localparam int unsigned PE_W = cnt_width(N_PERIODS);

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_HALF = PH_W'(PERIOD / 2);
    localparam logic [PE_W-1:0]  PE_LAST = PE_W'(N_PERIODS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    spad_state_t     state;
    spad_state_t     state_next;
    logic [PH_W-1:0] phase_cnt;
    logic [PE_W-1:0] period_cnt;
    logic            event_hit;
    logic            clear_frame;
    logic            frame_end;

`ifdef SPAD_SYNC_EN
    spad_pulse_sync u_pulse_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .spad_in (spad_in),
        .pulse   (event_hit)
    );
`else
    always_comb begin
        event_hit = spad_in;
    end
`endif

    always_comb begin
        state_next  = state;
        clear_frame = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        frame_end   = (phase_cnt == PH_LAST) && (period_cnt == PE_LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next  = INTEGRATE;
                    clear_frame = 1'b1;
                end
            end
            INTEGRATE: begin
                busy = 1'b1;
                if (frame_end) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ack) begin
                    if (start) begin
                        state_next  = INTEGRATE;
                        clear_frame = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            period_cnt <= '0;
            memory1    <= '0;
            memory2    <= '0;
        end else begin
            state <= state_next;
            if (clear_frame) begin
                phase_cnt  <= '0;
                period_cnt <= '0;
                memory1    <= '0;
                memory2    <= '0;
            end else if (state == INTEGRATE) begin
                if (phase_cnt == PH_LAST) begin
                    phase_cnt  <= '0;
                    period_cnt <= (period_cnt == PE_LAST) ? '0 : period_cnt + 1'b1;
                end else begin
                    phase_cnt <= phase_cnt + 1'b1;
                end
                // The event is attributed to the window of the current phase,
                // including the last cycle of the frame.
                if (event_hit) begin
                    if (phase_cnt < PH_HALF) begin
                        if (memory1 != CNT_MAX) memory1 <= memory1 + 1'b1;
                    end else begin
                        if (memory2 != CNT_MAX) memory2 <= memory2 + 1'b1;
                    end
                end
            end
        end
    end

endmodule
